// File: rtl/ff_ctrl_pkg.sv
// ff_ctrl_pkg: op/state encodings and sizing helper shared by the flop-bank scheduler.
package ff_ctrl_pkg;
    localparam logic [1:0] OPC_NOP   = 2'b00;
    localparam logic [1:0] OPC_CLR   = 2'b01;
    localparam logic [1:0] OPC_LOAD  = 2'b10;
    localparam logic [1:0] OPC_WRITE = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP   = OPC_NOP,
        OP_CLR   = OPC_CLR,
        OP_LOAD  = OPC_LOAD,
        OP_WRITE = OPC_WRITE
    } op_e;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_DONE} state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; search starts one past the last advanced grant.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          hit;

    always_comb begin
        idx_o = '0;
        hit   = 1'b0;
        // Scan from farthest to nearest so the nearest set request wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_q) + i) % N]) begin
                idx_o = IW'((int'(ptr_q) + i) % N);
                hit   = 1'b1;
            end
        end
        gnt_o = hit ? N'(1) << idx_o : '0;
        ptr_d = int'(idx_o) == N - 1 ? '0 : idx_o + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else if (adv_i && hit) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ff_ctrl_sched.sv
// ff_ctrl_sched: shares one control-gated flop bank among NREQ requesters (setup/pulse/hold).
// Define FFCTRL_VERIFY_EN to compare ff_q against the expected value in DONE (sticky err).
module ff_ctrl_sched
    import ff_ctrl_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  ff_r,
    output logic                  ff_aload,
    output logic [WIDTH-1:0]      ff_ad,
    output logic                  ff_e,
    output logic [WIDTH-1:0]      ff_d,
    input  logic [WIDTH-1:0]      ff_q,
    output logic                  err
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d, dat_q;
    logic [IW-1:0]     id_q, id_d, gidx;
    logic [NREQ-1:0]   gnt, done_q;
    logic              idle, adv, drive_d, pulse_d;
    logic              busy_q, r_q, aload_q, e_q;

    assign idle      = state_q == ST_IDLE && !rst;
    assign adv       = idle && |gnt;
    assign req_ready = idle ? gnt : '0;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .adv_i (adv),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: if (adv) begin
                op_d    = op_e'(req_op[2*gidx +: 2]);
                data_d  = req_data[WIDTH*gidx +: WIDTH];
                id_d    = gidx;
                state_d = op_d == OP_NOP ? ST_DONE : ST_SETUP;
                cnt_d   = S_LD;
            end
            ST_SETUP: if (cnt_q == '0) begin
                state_d = ST_PULSE;
                cnt_d   = P_LD;
            end else cnt_d = cnt_q - CW'(1);
            ST_PULSE: if (cnt_q == '0) begin
                state_d = ST_HOLD;
                cnt_d   = H_LD;
            end else cnt_d = cnt_q - CW'(1);
            ST_HOLD: if (cnt_q == '0) state_d = ST_DONE;
            else cnt_d = cnt_q - CW'(1);
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with the state they describe.
    assign drive_d = state_d == ST_SETUP || state_d == ST_PULSE || state_d == ST_HOLD;
    assign pulse_d = state_d == ST_PULSE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            r_q     <= 1'b0;
            aload_q <= 1'b0;
            e_q     <= 1'b0;
            dat_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            id_q    <= id_d;
            busy_q  <= state_d != ST_IDLE;
            r_q     <= pulse_d && op_d == OP_CLR;
            aload_q <= pulse_d && op_d == OP_LOAD;
            e_q     <= pulse_d && op_d == OP_WRITE;
            dat_q   <= drive_d ? data_d : '0;
            done_q  <= state_d == ST_DONE ? NREQ'(1) << id_d : '0;
        end
    end

    assign busy     = busy_q;
    assign ff_r     = r_q;
    assign ff_aload = aload_q;
    assign ff_e     = e_q;
    assign ff_d     = dat_q;
    assign ff_ad    = dat_q;
    assign done     = done_q;

`ifdef FFCTRL_VERIFY_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (state_q == ST_DONE && op_q != OP_NOP && ff_q != (op_q == OP_CLR ? '0 : data_q)) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    logic unused_ff_q;
    assign unused_ff_q = ^ff_q;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ff_ctrl_sched.sv
// tb_ff_ctrl_sched: vector table, corner sequences and a randomized run against a cycle-window model.
module tb_ff_ctrl_sched;
    localparam int N = 2, W = 4, S = 1, P = 1, H = 1, LAT = S + P + H + 1;
    localparam logic [1:0] NOP = 2'b00, CLR = 2'b01, LOAD = 2'b10, WRITE = 2'b11;

    typedef struct {
        int           id;
        logic [1:0]   op;
        logic [W-1:0] data;
        logic [2:0]   ctrl;
        logic [W-1:0] dexp;
        int           lat;
    } vec_t;

    logic           clk = 1'b0, rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready, done;
    logic           busy, ff_r, ff_aload, ff_e, err;
    logic [W-1:0]   ff_ad, ff_d, ff_q, bank_q;
    logic [W-1:0]   bad_val = '0;
    logic           bank_bad = 1'b0;
    int             tests = 0, fails = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) bank_q <= '0;
        else if (ff_r) bank_q <= '0;
        else if (ff_aload) bank_q <= ff_ad;
        else if (ff_e) bank_q <= ff_d;
    end
    assign ff_q = bank_bad ? bad_val : bank_q;

    ff_ctrl_sched #(.NREQ(N), .WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_ready(req_ready), .done(done), .busy(busy), .ff_r(ff_r), .ff_aload(ff_aload),
        .ff_ad(ff_ad), .ff_e(ff_e), .ff_d(ff_d), .ff_q(ff_q), .err(err)
    );

    function automatic logic [14:0] snap();
        return {err, busy, ff_r, ff_aload, ff_e, ff_d, ff_ad, done};
    endfunction

    function automatic logic [2:0] op_ctrl(input logic [1:0] op);
        return op == CLR ? 3'b100 : op == LOAD ? 3'b010 : op == WRITE ? 3'b001 : 3'b000;
    endfunction

    // Expected pins k cycles after accept: data over setup+pulse+hold, control only in the pulse window.
    function automatic logic [14:0] expect_at(input int id, input logic [2:0] ctrl, input logic [W-1:0] d,
                                              input int lat, input int k);
        logic [W-1:0] dd;
        logic [2:0]   cc;
        logic [N-1:0] dn;
        dd = k < lat ? d : '0;
        cc = (k > S && k <= S + P) ? ctrl : 3'b000;
        dn = k == lat ? N'(1) << id : '0;
        return {1'b0, 1'b1, cc, dd, dd, dn};
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++) if (v[(p + o) % N]) return N'(1) << ((p + o) % N);
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [W-1:0] d);
        req_valid[i]         = v;
        req_op[2*i +: 2]     = op;
        req_data[W*i +: W]   = d;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin
            tick;
            @(negedge clk);
            n++;
        end
        check("ready", req_ready, N'(1) << id);
    endtask

    task automatic run_op(input int id, input logic [1:0] op, input logic [W-1:0] d, input logic [2:0] ctrl,
                          input logic [W-1:0] dexp, input int lat, input string name);
        set_req(id, 1'b1, op, d);
        wait_ready(id);
        tick;
        set_req(id, 1'b0, NOP, '0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check(name, snap(), expect_at(id, ctrl, dexp, lat, k));
            tick;
        end
        @(negedge clk);
        check({name, "_idle"}, snap(), '0);
        tick;
    endtask

    vec_t vt[6];

    initial begin
        int g, t, last_t, ptr, kk, clat, cid;
        logic active;
        logic [N-1:0] prev, exp_g;
        logic [1:0] cop;
        logic [W-1:0] cd;
        logic verr;

        vt[0] = '{0, WRITE, 4'hA, 3'b001, 4'hA, LAT};
        vt[1] = '{1, LOAD,  4'h5, 3'b010, 4'h5, LAT};
        vt[2] = '{0, CLR,   4'h7, 3'b100, 4'h7, LAT};
        vt[3] = '{1, NOP,   4'hC, 3'b000, 4'h0, 1};
        vt[4] = '{1, WRITE, 4'hF, 3'b001, 4'hF, LAT};
        vt[5] = '{0, LOAD,  4'h0, 3'b010, 4'h0, LAT};

        // Reset state, with a request already pending.
        set_req(0, 1'b1, WRITE, 4'h5);
        repeat (3) tick;
        @(negedge clk);
        check("reset_out", snap(), '0);
        check("reset_ready", req_ready, '0);
        tick;
        set_req(0, 1'b0, NOP, '0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++)
            run_op(vt[i].id, vt[i].op, vt[i].data, vt[i].ctrl, vt[i].dexp, vt[i].lat, $sformatf("vec%0d", i));

        // Contention: both always valid, grants must alternate every S+P+H+2 cycles.
        do_reset;
        set_req(0, 1'b1, WRITE, 4'h1);
        set_req(1, 1'b1, WRITE, 4'h2);
        g = 0; t = 0; last_t = 0;
        while (g < 4 && t < 60) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("cont_order", req_ready, N'(1) << (g % 2));
                if (g > 0) check("cont_space", t - last_t, S + P + H + 2);
                last_t = t;
                g++;
            end
            tick;
            t++;
        end
        check("cont_count", g, 4);
        set_req(0, 1'b0, NOP, '0);
        set_req(1, 1'b0, NOP, '0);
        repeat (8) tick;

        // Reset during PULSE: pins drop, no done, pointer back to 0.
        do_reset;
        set_req(0, 1'b1, WRITE, 4'h9);
        wait_ready(0);
        tick;
        set_req(0, 1'b0, NOP, '0);
        @(negedge clk);
        check("rmp_setup", ff_d, 4'h9);
        tick;
        rst = 1'b1;
        @(negedge clk);
        check("rmp_pulse", ff_e, 1'b1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("rmp_clear", snap(), '0);
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            check("rmp_nodone", snap(), '0);
        end
        tick;
        set_req(0, 1'b1, WRITE, 4'h1);
        set_req(1, 1'b1, WRITE, 4'h2);
        @(negedge clk);
        check("rmp_next", req_ready, 2'b01);
        tick;
        set_req(0, 1'b0, NOP, '0);
        set_req(1, 1'b0, NOP, '0);
        repeat (8) tick;

        // Readback: faulty bank returns 0x2 for a WRITE of 0x3.
`ifdef FFCTRL_VERIFY_EN
        verr = 1'b1;
`else
        verr = 1'b0;
`endif
        do_reset;
        bank_bad = 1'b1;
        bad_val  = 4'h2;
        set_req(0, 1'b1, WRITE, 4'h3);
        wait_ready(0);
        tick;
        set_req(0, 1'b0, NOP, '0);
        repeat (LAT - 1) tick;
        @(negedge clk);
        check("vfy_in_done", {err, done}, {1'b0, 2'b01});
        tick;
        @(negedge clk);
        check("vfy_err", err, verr);
        repeat (3) tick;
        @(negedge clk);
        check("vfy_hold", err, verr);
        bank_bad = 1'b0;
        tick;
        do_reset;
        @(negedge clk);
        check("vfy_rst", err, 1'b0);
        tick;
        run_op(0, WRITE, 4'h3, 3'b001, 4'h3, LAT, "vfy_good");

        // Randomized traffic against the window model.
        do_reset;
        ptr = 0; active = 1'b0; prev = '0; kk = 0; clat = 0; cid = 0; cop = NOP; cd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (prev[i]) set_req(i, 1'b0, NOP, '0);
                else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, 2'($urandom_range(0, 3)), W'($urandom));
                end else if ($urandom_range(0, 15) == 0) set_req(i, 1'b0, NOP, '0);
            end
            @(negedge clk);
            if (!active) begin
                exp_g = rr_pick(req_valid, ptr);
                check("rnd_grant", req_ready, exp_g);
                check("rnd_idle", snap(), '0);
                if (exp_g != '0) begin
                    for (int i = 0; i < N; i++) if (exp_g[i]) cid = i;
                    cop    = req_op[2*cid +: 2];
                    cd     = req_data[W*cid +: W];
                    clat   = cop == NOP ? 1 : LAT;
                    kk     = 0;
                    active = 1'b1;
                    ptr    = (cid + 1) % N;
                end
            end else begin
                kk++;
                check("rnd_busy_ready", req_ready, '0);
                check("rnd_seq", snap(), expect_at(cid, op_ctrl(cop), cd, clat, kk));
                if (kk == clat) active = 1'b0;
            end
            prev = req_ready;
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
